alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Sequencing controller that shares one combinational 64-bit ALU between two requesters. It arbitrates round-robin, registers the granted operands and opcode onto the ALU inputs, and captures the ALU result and zero flag into a response register. It holds that response under valid/ready backpressure until the owning requester takes it. Unsupported opcodes are filtered out here and never reach the ALU.

## Interface
- WIDTH, 64, operand/result width
- RR_INIT, 0, requester holding priority after reset (0 or 1)

- CLK  in  1  clock, all state updates on rising edge
- ResetL  in  1  synchronous, active-low reset
- ReqValid0 / ReqValid1  in  1  requester n presents an operation
- ReqReady0 / ReqReady1  out  1  controller accepts requester n this cycle
- ReqA0 / ReqA1  in  WIDTH  operand A
- ReqB0 / ReqB1  in  WIDTH  operand B
- ReqCtrl0 / ReqCtrl1  in  4  opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 PassB
- RspValid0 / RspValid1  out  1  response for requester n valid
- RspReady0 / RspReady1  in  1  requester n takes response
- RspW  out  WIDTH  result (shared, qualified by RspValidn)
- RspZero  out  1  zero flag of result
- RspErr  out  1  1 = opcode rejected
- AluA / AluB  out  WIDTH  to ALU BusA/BusB
- AluCtrl  out  4  to ALU ALUCtrl
- AluW  in  WIDTH  from ALU BusW
- AluZero  in  1  from ALU Zero

## Operation
- States: IDLE, EXEC, RESP. Registers: state, priority pointer P, owner O, OpA, OpB, OpCtrl, RspW, RspZero, RspErr.
- IDLE grant: both valid -> grant P; one valid -> grant it; none -> no grant. ReqReadyn = ResetL & (state==IDLE) & granted==n. Ready depends on valid; requesters must not make valid depend on ready.
- Accept (IDLE, ReqValidn & ReqReadyn): OpA, OpB, OpCtrl <= requester n fields; O <= n.
  - Legal opcode: next state EXEC.
  - Illegal opcode (any value outside the five listed): OpCtrl unchanged, RspW <= 0, RspZero <= 0, RspErr <= 1, next state RESP.
- AluA = OpA, AluB = OpB, AluCtrl = OpCtrl at all times (registered; stable across EXEC).
- EXEC: RspW <= AluW, RspZero <= AluZero, RspErr <= 0; next state RESP. No width change; ADD/SUB wrap modulo 2^WIDTH.
- RESP: RspValidO = 1, other RspValid = 0; RspW/RspZero/RspErr held. RspReadyO=1 -> P <= ~O, next state IDLE. RspReady of non-owner ignored.
- Priority updates only on response completion; starvation-free with two requesters.
- Reset (ResetL low at an edge): state IDLE, P = RR_INIT, O = 0, OpA = OpB = 0, OpCtrl = 0000, RspW = 0, RspZero = 0, RspErr = 0. ReqReadyn and RspValidn are forced to 0 while ResetL is low. A reset during EXEC or RESP discards the operation; no response is issued afterwards.

## Timing
- Accept at edge ending cycle n -> EXEC in n+1 (ALU sees operands) -> RspValid in n+2.
- Illegal opcode: RspValid in n+1.
- RspReady in the first RESP cycle -> IDLE next cycle; next accept possible in that cycle. Minimum issue period is 3 cycles legal, 2 illegal.
- RESP holds indefinitely while RspReadyO=0; RspW, RspZero and RspErr are unchanged throughout.
- No request is accepted outside IDLE, so ReqReadyn = 0 during EXEC and RESP regardless of valid.
- Simultaneous ReqValid0 & ReqValid1 in IDLE: exactly one ReqReady high, matching P.

## Test plan
- Reset then single op: ResetL low 2 cycles; req0 ADD A=5 B=7 -> ReqReady0 same cycle, RspValid0 two cycles later, RspW=12, RspZero=0, RspErr=0. All outputs 0 during reset.
- SUB to zero and wrap: req1 SUB A=3 B=3 -> RspW=0, RspZero=1. SUB A=0 B=1 -> RspW=0xFFFF_FFFF_FFFF_FFFF, RspZero=0.
- Contention with RR_INIT=0: both valid continuously with AND, OR, PassB -> grants alternate 0,1,0,1. Each response goes only to its owner: AND 0xF0 & 0x3C = 0x30; PassB B=0xABC = 0xABC.
- Backpressure: hold RspReady0=0 for 5 cycles -> RspValid0 stays 1, RspW stable, ReqReady1=0 despite ReqValid1=1. Release -> req1 accepted the next cycle.
- Illegal opcode: req0 ReqCtrl=1111 -> RspValid0 one cycle after accept, RspErr=1, RspW=0, AluCtrl unchanged.
- Reset mid-op: assert ResetL low during EXEC -> no RspValid afterwards, state IDLE, P=RR_INIT. A new request after reset completes normally.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// Round-robin controller that time-shares one combinational ALU between two
// requesters, filters illegal opcodes and holds each response until its owner takes it.
module alu_share_ctrl #(
  parameter int WIDTH   = 64,
  parameter bit RR_INIT = 1'b0
) (
  input  logic             CLK,
  input  logic             ResetL,
  input  logic             ReqValid0,
  input  logic             ReqValid1,
  output logic             ReqReady0,
  output logic             ReqReady1,
  input  logic [WIDTH-1:0] ReqA0,
  input  logic [WIDTH-1:0] ReqA1,
  input  logic [WIDTH-1:0] ReqB0,
  input  logic [WIDTH-1:0] ReqB1,
  input  logic [3:0]       ReqCtrl0,
  input  logic [3:0]       ReqCtrl1,
  output logic             RspValid0,
  output logic             RspValid1,
  input  logic             RspReady0,
  input  logic             RspReady1,
  output logic [WIDTH-1:0] RspW,
  output logic             RspZero,
  output logic             RspErr,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic [3:0]       AluCtrl,
  input  logic [WIDTH-1:0] AluW,
  input  logic             AluZero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic             prio;
  logic             owner;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       op_ctrl;

  logic             grant_any;
  logic             grant_sel;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [3:0]       sel_ctrl;
  logic             owner_ready;

  function automatic logic op_legal(input logic [3:0] ctrl);
    case (ctrl)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111: op_legal = 1'b1;
      default:                                     op_legal = 1'b0;
    endcase
  endfunction

  // Priority only breaks ties; a lone valid requester is always granted.
  always_comb begin
    grant_any = ReqValid0 | ReqValid1;
    grant_sel = (ReqValid0 & ReqValid1) ? prio : ReqValid1;
  end

  assign ReqReady0 = ResetL & (state == IDLE) & grant_any & ~grant_sel;
  assign ReqReady1 = ResetL & (state == IDLE) & grant_any &  grant_sel;
  assign accept    = ReqReady0 | ReqReady1;

  assign sel_a    = grant_sel ? ReqA1    : ReqA0;
  assign sel_b    = grant_sel ? ReqB1    : ReqB0;
  assign sel_ctrl = grant_sel ? ReqCtrl1 : ReqCtrl0;

  assign RspValid0   = ResetL & (state == RESP) & ~owner;
  assign RspValid1   = ResetL & (state == RESP) &  owner;
  assign owner_ready = owner ? RspReady1 : RspReady0;

  assign AluA    = op_a;
  assign AluB    = op_b;
  assign AluCtrl = op_ctrl;

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!ResetL) begin
      state   <= IDLE;
      prio    <= RR_INIT;
      owner   <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      op_ctrl <= 4'b0000;
      RspW    <= '0;
      RspZero <= 1'b0;
      RspErr  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a  <= sel_a;
            op_b  <= sel_b;
            owner <= grant_sel;
            if (op_legal(sel_ctrl)) begin
              op_ctrl <= sel_ctrl;
              state   <= EXEC;
            end else begin
              // Rejected opcodes never reach the ALU control input.
              RspW    <= '0;
              RspZero <= 1'b0;
              RspErr  <= 1'b1;
              state   <= RESP;
            end
          end
        end
        EXEC: begin
          RspW    <= AluW;
          RspZero <= AluZero;
          RspErr  <= 1'b0;
          state   <= RESP;
        end
        RESP: begin
          if (owner_ready) begin
            prio  <= ~owner;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: a behavioural ALU closes the loop and
// every response is compared against hand-computed values.
module tb_alu_share_ctrl;

  localparam int WIDTH = 64;

  logic             CLK;
  logic             ResetL;
  logic             ReqValid0, ReqValid1;
  logic             ReqReady0, ReqReady1;
  logic [WIDTH-1:0] ReqA0, ReqA1, ReqB0, ReqB1;
  logic [3:0]       ReqCtrl0, ReqCtrl1;
  logic             RspValid0, RspValid1;
  logic             RspReady0, RspReady1;
  logic [WIDTH-1:0] RspW;
  logic             RspZero, RspErr;
  logic [WIDTH-1:0] AluA, AluB;
  logic [3:0]       AluCtrl;
  logic [WIDTH-1:0] AluW;
  logic             AluZero;

  int total = 0;
  int bad   = 0;

  alu_share_ctrl #(.WIDTH(WIDTH), .RR_INIT(1'b0)) dut (
    .CLK(CLK), .ResetL(ResetL),
    .ReqValid0(ReqValid0), .ReqValid1(ReqValid1),
    .ReqReady0(ReqReady0), .ReqReady1(ReqReady1),
    .ReqA0(ReqA0), .ReqA1(ReqA1), .ReqB0(ReqB0), .ReqB1(ReqB1),
    .ReqCtrl0(ReqCtrl0), .ReqCtrl1(ReqCtrl1),
    .RspValid0(RspValid0), .RspValid1(RspValid1),
    .RspReady0(RspReady0), .RspReady1(RspReady1),
    .RspW(RspW), .RspZero(RspZero), .RspErr(RspErr),
    .AluA(AluA), .AluB(AluB), .AluCtrl(AluCtrl),
    .AluW(AluW), .AluZero(AluZero)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Stand-in for the shared combinational ALU.
  always_comb begin
    case (AluCtrl)
      4'b0000: AluW = AluA & AluB;
      4'b0001: AluW = AluA | AluB;
      4'b0010: AluW = AluA + AluB;
      4'b0110: AluW = AluA - AluB;
      4'b0111: AluW = AluB;
      default: AluW = '0;
    endcase
    AluZero = (AluW == '0);
  end

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one full clock period; stimulus and sampling happen near the falling edge.
  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  initial begin
    ResetL = 1'b0;
    ReqValid0 = 1'b0; ReqValid1 = 1'b0;
    ReqA0 = '0; ReqA1 = '0; ReqB0 = '0; ReqB1 = '0;
    ReqCtrl0 = 4'b0000; ReqCtrl1 = 4'b0000;
    RspReady0 = 1'b0; RspReady1 = 1'b0;

    // Reset held for two edges with a request pending: outputs must stay zero.
    step();
    ReqValid0 = 1'b1; ReqA0 = 64'd5; ReqB0 = 64'd7; ReqCtrl0 = 4'b0010;
    step();
    #1;
    check("rst_ready0", {63'd0, ReqReady0}, 64'd0);
    check("rst_rspvalid0", {63'd0, RspValid0}, 64'd0);
    check("rst_rspw", RspW, 64'd0);
    check("rst_alua", AluA, 64'd0);
    check("rst_aluctrl", {60'd0, AluCtrl}, 64'd0);

    // Single ADD 5+7 from requester 0.
    ResetL = 1'b1;
    #1;
    check("add_ready0", {63'd0, ReqReady0}, 64'd1);
    check("add_ready1", {63'd0, ReqReady1}, 64'd0);
    step();
    ReqValid0 = 1'b0;
    check("add_exec_rspvalid0", {63'd0, RspValid0}, 64'd0);
    check("add_exec_alua", AluA, 64'd5);
    check("add_exec_alub", AluB, 64'd7);
    check("add_exec_aluctrl", {60'd0, AluCtrl}, 64'd2);
    step();
    check("add_rspvalid0", {63'd0, RspValid0}, 64'd1);
    check("add_rspvalid1", {63'd0, RspValid1}, 64'd0);
    check("add_rspw", RspW, 64'd12);
    check("add_zero", {63'd0, RspZero}, 64'd0);
    check("add_err", {63'd0, RspErr}, 64'd0);
    RspReady0 = 1'b1;
    step();
    RspReady0 = 1'b0;

    // SUB 3-3 from requester 1: zero result.
    ReqValid1 = 1'b1; ReqA1 = 64'd3; ReqB1 = 64'd3; ReqCtrl1 = 4'b0110;
    #1;
    check("sub0_ready1", {63'd0, ReqReady1}, 64'd1);
    step();
    ReqValid1 = 1'b0;
    step();
    check("sub0_rspvalid1", {63'd0, RspValid1}, 64'd1);
    check("sub0_rspvalid0", {63'd0, RspValid0}, 64'd0);
    check("sub0_rspw", RspW, 64'd0);
    check("sub0_zero", {63'd0, RspZero}, 64'd1);
    RspReady1 = 1'b1;
    step();
    RspReady1 = 1'b0;

    // SUB 0-1 wraps to all ones.
    ReqValid1 = 1'b1; ReqA1 = 64'd0; ReqB1 = 64'd1; ReqCtrl1 = 4'b0110;
    step();
    ReqValid1 = 1'b0;
    step();
    check("subwrap_rspw", RspW, 64'hFFFF_FFFF_FFFF_FFFF);
    check("subwrap_zero", {63'd0, RspZero}, 64'd0);
    RspReady1 = 1'b1;
    step();
    RspReady1 = 1'b0;

    // Contention: priority is back at 0, both requesters stay valid.
    ReqValid0 = 1'b1; ReqA0 = 64'hF0; ReqB0 = 64'h3C; ReqCtrl0 = 4'b0000;
    ReqValid1 = 1'b1; ReqA1 = 64'h0F; ReqB1 = 64'hF0; ReqCtrl1 = 4'b0001;
    #1;
    check("rr1_ready0", {63'd0, ReqReady0}, 64'd1);
    check("rr1_ready1", {63'd0, ReqReady1}, 64'd0);
    step();
    ReqA0 = 64'h123; ReqB0 = 64'hABC; ReqCtrl0 = 4'b0111;
    #1;
    check("rr1_exec_ready0", {63'd0, ReqReady0}, 64'd0);
    check("rr1_exec_ready1", {63'd0, ReqReady1}, 64'd0);
    step();
    check("rr1_rspvalid0", {63'd0, RspValid0}, 64'd1);
    check("rr1_rspvalid1", {63'd0, RspValid1}, 64'd0);
    check("rr1_and_rspw", RspW, 64'h30);
    check("rr1_resp_ready1", {63'd0, ReqReady1}, 64'd0);
    RspReady0 = 1'b1;
    step();
    RspReady0 = 1'b0;
    check("rr2_ready1", {63'd0, ReqReady1}, 64'd1);
    check("rr2_ready0", {63'd0, ReqReady0}, 64'd0);
    step();
    ReqA1 = 64'd1; ReqB1 = 64'd1; ReqCtrl1 = 4'b0010;
    step();
    check("rr2_rspvalid1", {63'd0, RspValid1}, 64'd1);
    check("rr2_rspvalid0", {63'd0, RspValid0}, 64'd0);
    check("rr2_or_rspw", RspW, 64'hFF);
    RspReady1 = 1'b1;
    step();
    RspReady1 = 1'b0;
    check("rr3_ready0", {63'd0, ReqReady0}, 64'd1);
    check("rr3_ready1", {63'd0, ReqReady1}, 64'd0);
    step();
    ReqValid0 = 1'b0;
    step();
    check("rr3_passb_rspw", RspW, 64'hABC);

    // Backpressure on owner 0; non-owner ready must be ignored.
    RspReady1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_rspvalid0", {63'd0, RspValid0}, 64'd1);
      check("bp_rspw", RspW, 64'hABC);
      check("bp_ready1", {63'd0, ReqReady1}, 64'd0);
    end
    RspReady1 = 1'b0;
    RspReady0 = 1'b1;
    step();
    RspReady0 = 1'b0;
    check("rr4_ready1", {63'd0, ReqReady1}, 64'd1);
    step();
    ReqValid1 = 1'b0;
    step();
    check("rr4_add_rspw", RspW, 64'd2);
    check("rr4_rspvalid1", {63'd0, RspValid1}, 64'd1);
    RspReady1 = 1'b1;
    step();
    RspReady1 = 1'b0;

    // Illegal opcode: response one cycle after accept, ALU control untouched.
    ReqValid0 = 1'b1; ReqA0 = 64'd9; ReqB0 = 64'd9; ReqCtrl0 = 4'b1111;
    step();
    ReqValid0 = 1'b0;
    check("ill_rspvalid0", {63'd0, RspValid0}, 64'd1);
    check("ill_err", {63'd0, RspErr}, 64'd1);
    check("ill_rspw", RspW, 64'd0);
    check("ill_zero", {63'd0, RspZero}, 64'd0);
    check("ill_aluctrl", {60'd0, AluCtrl}, 64'd2);
    RspReady0 = 1'b1;
    step();
    RspReady0 = 1'b0;

    // Reset during EXEC: priority is 1 here, reset must restore 0.
    ReqValid1 = 1'b1; ReqA1 = 64'd4; ReqB1 = 64'd4; ReqCtrl1 = 4'b0010;
    step();
    ReqValid1 = 1'b0;
    check("mid_exec_aluctrl", {60'd0, AluCtrl}, 64'd2);
    ResetL = 1'b0;
    ReqValid0 = 1'b1; ReqValid1 = 1'b1;
    #1;
    check("mid_rst_ready0", {63'd0, ReqReady0}, 64'd0);
    check("mid_rst_ready1", {63'd0, ReqReady1}, 64'd0);
    step();
    ResetL = 1'b1;
    ReqValid0 = 1'b0; ReqValid1 = 1'b0;
    #1;
    check("mid_rspvalid0", {63'd0, RspValid0}, 64'd0);
    check("mid_rspvalid1", {63'd0, RspValid1}, 64'd0);
    check("mid_alua", AluA, 64'd0);
    step();
    check("mid_late_rspvalid1", {63'd0, RspValid1}, 64'd0);
    check("mid_late_rspw", RspW, 64'd0);

    // Priority back at RR_INIT, then a normal operation completes.
    ReqValid0 = 1'b1; ReqA0 = 64'd10; ReqB0 = 64'd20; ReqCtrl0 = 4'b0010;
    ReqValid1 = 1'b1; ReqA1 = 64'd1; ReqB1 = 64'd1; ReqCtrl1 = 4'b0010;
    #1;
    check("post_ready0", {63'd0, ReqReady0}, 64'd1);
    check("post_ready1", {63'd0, ReqReady1}, 64'd0);
    step();
    ReqValid0 = 1'b0; ReqValid1 = 1'b0;
    step();
    check("post_rspvalid0", {63'd0, RspValid0}, 64'd1);
    check("post_rspw", RspW, 64'd30);
    check("post_err", {63'd0, RspErr}, 64'd0);
    RspReady0 = 1'b1;
    step();
    RspReady0 = 1'b0;
    check("post_idle_rspvalid0", {63'd0, RspValid0}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
